// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode 0 responder with one-entry TX/RX holding registers, oversampled by CLK.
module spi_slave_port #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             WRITE,
  input  logic             READ,
  output logic [WIDTH-1:0] DATA_OUT,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  output logic             TX_FULL_STATE,
  output logic             TX_EMPTY_STATE,
  output logic             RX_FULL_STATE,
  output logic             RX_EMPTY_STATE,
  output logic             OVERRUN,
  output logic             BUSY
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]       sclk_q, ss_q;
  logic [1:0]       mosi_q;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d, data_q, data_d;
  logic             tx_full_q, tx_full_d, rx_full_q, rx_full_d, overrun_q, overrun_d;
  logic             ss_fall, ss_rise, sclk_rise, sclk_fall, last, load, shift, done;
  logic             use_hold, wr_ok, rd_ok, store;
  logic [WIDTH-1:0] word;
  // Index 2 is the registered copy of the synchroniser output, used only for edge detection.
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign word      = {rx_shift_q, mosi_q[1]};
  assign last      = bit_cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    load       = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = ACTIVE;
        bit_cnt_d = '0;
        load      = 1'b1;
      end
    end else if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      rx_shift_d = word[WIDTH-2:0];
      bit_cnt_d  = last ? '0 : bit_cnt_q + CW'(1);
      done       = last;
    end else if (sclk_fall) begin
      load  = bit_cnt_q == '0;
      shift = bit_cnt_q != '0;
    end
  end
  // The shifter never bypasses a WRITE landing in the load cycle; it only sees the old holding value.
  assign use_hold   = load & tx_full_q;
  assign tx_shift_d = load ? (tx_full_q ? tx_hold_q : IDLE_WORD)
                    : shift ? {tx_shift_q[WIDTH-2:0], 1'b0} : tx_shift_q;
  assign wr_ok      = WRITE & (~tx_full_q | use_hold);
  assign tx_full_d  = (tx_full_q & ~use_hold) | wr_ok;
  assign tx_hold_d  = wr_ok ? DATA_IN : tx_hold_q;
  assign rd_ok      = READ & rx_full_q;
  assign store      = done & (~rx_full_q | READ);
  assign rx_full_d  = store | (rx_full_q & ~rd_ok);
  assign data_d     = store ? word : data_q;
  assign overrun_d  = (done & rx_full_q & ~READ) | (overrun_q & ~rd_ok);
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sclk_q     <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      data_q     <= '0;
      tx_full_q  <= 1'b0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= {sclk_q[1:0], SCLK};
      ss_q       <= {ss_q[1:0], SS_N};
      mosi_q     <= {mosi_q[0], MOSI};
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      data_q     <= data_d;
      tx_full_q  <= tx_full_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
    end
  end
  assign BUSY           = state_q == ACTIVE;
  assign MISO_OE        = BUSY;
  assign MISO           = BUSY & tx_shift_q[WIDTH-1];
  assign DATA_OUT       = data_q;
  assign TX_FULL_STATE  = tx_full_q;
  assign TX_EMPTY_STATE = ~tx_full_q;
  assign RX_FULL_STATE  = rx_full_q;
  assign RX_EMPTY_STATE = ~rx_full_q;
  assign OVERRUN        = overrun_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed SPI master and host stimulus with hand-computed expectations.
module tb_spi_slave_port;
  logic       clk = 1'b0, clr = 1'b1, wr = 1'b0, rd = 1'b0;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [7:0] din = '0, dout, got, got2, got3;
  logic       miso, miso_oe, tx_full, tx_empty, rx_full, rx_empty, ovr, busy;
  int         n_chk = 0, n_pass = 0;
  spi_slave_port #(.WIDTH(8)) dut (
    .CLK(clk), .CLR(clr), .DATA_IN(din), .WRITE(wr), .READ(rd), .DATA_OUT(dout),
    .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi), .MISO(miso), .MISO_OE(miso_oe),
    .TX_FULL_STATE(tx_full), .TX_EMPTY_STATE(tx_empty), .RX_FULL_STATE(rx_full),
    .RX_EMPTY_STATE(rx_empty), .OVERRUN(ovr), .BUSY(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic host_wr(input logic [7:0] d);
    din = d;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
  endtask
  task automatic host_rd;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask
  // Select; optionally strobe WRITE in exactly the cycle the frame load registers.
  task automatic sel(input bit w, input logic [7:0] d);
    ss_n = 1'b0;
    cyc(2);
    if (w) begin
      wr = 1'b1;
      din = d;
    end
    cyc(1);
    wr = 1'b0;
    cyc(2);
  endtask
  task automatic desel;
    cyc(5);
    ss_n = 1'b1;
    cyc(5);
  endtask
  // Mode 0 master: 5 CLK low then 5 CLK high per bit; optional READ in the completion cycle.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit rd_last, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      cyc(5);
      rxb = {rxb[6:0], miso};
      sclk = 1'b1;
      cyc(2);
      rd = rd_last && (i == nbits - 1);
      cyc(1);
      rd = 1'b0;
      cyc(2);
      sclk = 1'b0;
    end
  endtask
  initial begin
    cyc(2);
    chk("reset_state", {tx_empty, rx_empty, miso_oe, busy, miso, ovr, dout}, {6'b110000, 8'h00});
    for (int i = 0; i < 2; i++) begin
      sclk = ~sclk;
      cyc(1);
    end
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      cyc(5);
      chk("idle_sclk", {tx_empty, rx_empty, miso_oe, busy, dout}, {4'b1100, 8'h00});
    end
    host_wr(8'h43);
    chk("wr_full", tx_full, 1'b1);
    sel(1'b0, 8'h00);
    chk("sel_busy", {busy, miso_oe, tx_empty}, 3'b111);
    xfer(8'h5F, 8, 1'b0, got);
    chk("single_miso", got, 8'h43);
    chk("single_rx", {rx_full, rx_empty, dout}, {2'b10, 8'h5F});
    desel;
    chk("desel_oe", {miso_oe, busy, miso}, 3'b000);
    host_rd;
    chk("read_pop", {rx_full, rx_empty, dout}, {2'b01, 8'h5F});
    sel(1'b0, 8'h00);
    xfer(8'hA5, 8, 1'b0, got);
    desel;
    chk("empty_tx_miso", got, 8'hFF);
    chk("empty_tx_rx", {rx_full, dout}, {1'b1, 8'hA5});
    host_rd;
    host_wr(8'h12);
    sel(1'b0, 8'h00);
    host_wr(8'h34);
    xfer(8'h11, 8, 1'b0, got);
    xfer(8'h22, 8, 1'b0, got2);
    xfer(8'h33, 8, 1'b0, got3);
    desel;
    chk("b2b_miso0", got, 8'h12);
    chk("b2b_miso1", got2, 8'h34);
    chk("b2b_miso2", got3, 8'hFF);
    chk("overrun", {rx_full, ovr, tx_empty, dout}, {3'b111, 8'h11});
    host_rd;
    chk("overrun_clr", {rx_full, ovr, dout}, {2'b00, 8'h11});
    sel(1'b0, 8'h00);
    xfer(8'hF0, 5, 1'b0, got);
    ss_n = 1'b1;
    cyc(3);
    chk("abort_oe", {miso_oe, busy, miso}, 3'b000);
    chk("abort_rx", {rx_empty, ovr, dout}, {2'b10, 8'h11});
    cyc(3);
    sel(1'b0, 8'h00);
    xfer(8'h0F, 8, 1'b0, got);
    desel;
    chk("after_abort_rx", {rx_full, dout}, {1'b1, 8'h0F});
    chk("after_abort_miso", got, 8'hFF);
    host_wr(8'hAA);
    sel(1'b0, 8'h00);
    host_wr(8'hBB);
    xfer(8'h3C, 3, 1'b0, got);
    chk("pre_clr", {busy, tx_full, rx_full}, 3'b111);
    clr = 1'b1;
    #1;
    chk("mid_clr", {tx_empty, rx_empty, miso_oe, busy, miso, ovr, dout}, {6'b110000, 8'h00});
    cyc(1);
    ss_n = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(5);
    sel(1'b0, 8'h00);
    xfer(8'h5A, 8, 1'b0, got);
    chk("coin_rd_first", {rx_full, dout}, {1'b1, 8'h5A});
    xfer(8'hC3, 8, 1'b1, got);
    desel;
    chk("coin_rd", {rx_full, ovr, dout}, {2'b10, 8'hC3});
    host_rd;
    host_wr(8'h77);
    sel(1'b1, 8'h88);
    chk("coin_wr_hold", {tx_full, busy}, 2'b11);
    xfer(8'h00, 8, 1'b0, got);
    xfer(8'h00, 8, 1'b0, got2);
    desel;
    chk("coin_wr_old", got, 8'h77);
    chk("coin_wr_new", got2, 8'h88);
    chk("coin_wr_empty", tx_empty, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- Responder end of the team's SPI link, clocked by a single system clock.
- Receives SCLK, SS_N and MOSI from an external SPI master and oversamples them with CLK.
- Shifts received bits into a one-entry RX holding register and drives MISO from a one-entry TX holding register.
- The local host side uses the same WRITE/READ/FULL/EMPTY style as the existing sender/receiver pair. SPI mode 0, MSB first.

Parameters:
- WIDTH, 8, bits per SPI frame and width of DATA_IN/DATA_OUT.
- IDLE_WORD, {WIDTH{1'b1}}, word shifted out on MISO when TX holding is empty at frame load.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- CLR  input  1  asynchronous active-high reset.
- DATA_IN  input  WIDTH  word for host to transmit.
- WRITE  input  1  load DATA_IN into TX holding (single-cycle strobe).
- READ  input  1  pop RX holding (single-cycle strobe).
- DATA_OUT  output  WIDTH  RX holding register; valid while RX_FULL_STATE=1.
- SCLK  input  1  serial clock from master, asynchronous to CLK.
- SS_N  input  1  active-low slave select, asynchronous.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master.
- MISO_OE  output  1  MISO drive enable; 1 only while selected.
- TX_FULL_STATE / TX_EMPTY_STATE  output  1 each  TX holding occupancy; always complementary.
- RX_FULL_STATE / RX_EMPTY_STATE  output  1 each  RX holding occupancy; always complementary.
- OVERRUN  output  1  sticky: a completed frame was dropped because RX holding was full.
- BUSY  output  1  high while selected (state ACTIVE).

Behaviour:
- Reset (CLR=1, async):
  - All registers cleared; DATA_OUT=0, MISO=0, MISO_OE=0, BUSY=0, OVERRUN=0.
  - TX_EMPTY_STATE=1, RX_EMPTY_STATE=1, bit counter=0, state IDLE.
  - CLR asserted mid-frame aborts immediately; the partial frame is lost.
- Input synchronisation:
  - SCLK, SS_N and MOSI each pass through a 2-flop synchroniser, followed by a registered copy for edge detection.
  - Edge detect latency: 3 CLK from pin to action.
  - Legal SCLK high and low phases are each >= 4 CLK periods; behaviour for faster SCLK is undefined.
- State machine, IDLE -> ACTIVE:
  - Trigger: synchronised SS_N falling edge.
  - Frame load: tx_shift <= TX holding if TX_FULL_STATE, else IDLE_WORD; TX holding is freed if used.
  - bit_cnt <= 0; MISO_OE=1; MISO = tx_shift MSB from the next cycle.
- State machine, ACTIVE -> IDLE:
  - Trigger: synchronised SS_N rising edge, at any bit position.
  - Partial RX bits are discarded (no RX update, no OVERRUN); bit_cnt <= 0; MISO_OE=0; MISO=0.
  - Any unsent bits of tx_shift are discarded and the TX holding contents are untouched.
- ACTIVE, SCLK rising (sample):
  - rx_shift <= {rx_shift[WIDTH-2:0], MOSI_sync}; bit_cnt increments and wraps WIDTH-1 -> 0.
  - On the WIDTH-th rise, with RX empty: DATA_OUT <= complete word, RX_FULL_STATE=1.
  - On the WIDTH-th rise, with RX full and no READ that cycle: word dropped, OVERRUN=1, DATA_OUT unchanged.
- ACTIVE, SCLK falling (shift):
  - If bit_cnt==0 (frame boundary, not first frame): reload tx_shift from holding or IDLE_WORD, same rule as frame load.
  - Otherwise: tx_shift shifts left by one.
  - Back-to-back frames are supported without deasserting SS_N.
- Host WRITE:
  - TX empty: holding <= DATA_IN, TX_FULL_STATE=1 next cycle.
  - TX full: WRITE ignored, holding keeps its old value.
  - WRITE in the same cycle as a frame load with TX full: shifter takes the old holding, holding takes the new DATA_IN, TX_FULL stays 1.
  - WRITE in the same cycle as a frame load with TX empty: shifter takes IDLE_WORD (no bypass), holding takes DATA_IN.
- Host READ:
  - RX full: RX_FULL_STATE=0 next cycle; DATA_OUT retains its value; OVERRUN cleared.
  - RX empty: READ ignored.
  - READ in the same cycle as a frame completion with RX full: the new word is stored, RX_FULL stays 1, no OVERRUN.
- Other rules:
  - WRITE and READ are independent and may coincide.
  - SCLK edges while IDLE are ignored.

Test Plan:
1. Reset then idle: CLR pulse with SCLK toggling and SS_N=1 -> TX_EMPTY=1, RX_EMPTY=1, MISO_OE=0, BUSY=0, DATA_OUT=8'h00 throughout.
2. Single frame: WRITE 8'h43, then the bench master drives SS_N low and shifts 8'h5F on MOSI (SCLK period 10 CLK) -> master captures 8'h43 on MISO; after the 8th rise plus 3 CLK, RX_FULL=1 and DATA_OUT=8'h5F; TX_EMPTY=1.
3. Empty TX: no WRITE, master sends 8'hA5 -> MISO returns 8'hFF; DATA_OUT=8'hA5.
4. Back-to-back with overrun: WRITE 8'h12, then WRITE 8'h34 after the first load; master sends 8'h11, 8'h22, 8'h33 in one SS_N window with no READ -> MISO 8'h12, 8'h34, 8'hFF; DATA_OUT=8'h11, OVERRUN=1; a READ clears RX_FULL and OVERRUN.
5. Abort: SS_N rises after 5 bits of 8'hF0 -> RX unchanged, RX_EMPTY=1, MISO_OE=0 within 3 CLK; the next full frame 8'h0F is received correctly (bit counter was reset).
6. Mid-frame reset and coincident strobes: CLR asserted at bit 3 -> all outputs reach reset values in the same cycle. Also: READ coincident with a frame completion while RX is full -> new word stored, no OVERRUN. Also: WRITE coincident with a frame load while TX is full -> old word sent, new word held.
